// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the EX->MEM pipeline stage:
//                payload struct, skid-buffer state enum, default widths and
//                control-vector bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   // Default widths of the EX->MEM payload fields
   localparam int c_PC_W   = 16;
   localparam int c_DATA_W = 32;
   localparam int c_RA_W   = 5;
   localparam int c_CTRL_W = 8;
   localparam int c_CNT_W  = 16;

   // Bubble control word: MemRead_n high (no read), everything else off
   localparam logic [c_CTRL_W-1:0] c_CTRL_RST = 8'h02;

   // Bit positions inside the packed control vector
   localparam int c_CTRL_REGWRITE  = 0;
   localparam int c_CTRL_MEMREAD_N = 1;
   localparam int c_CTRL_MEMTOREG  = 2;
   localparam int c_CTRL_BRANCH    = 3;
   localparam int c_CTRL_ZERO      = 4;

   // One in-flight instruction as it crosses from EX to MEM
   typedef struct packed {
      logic [c_PC_W-1:0]   pc;
      logic [c_DATA_W-1:0] alu;
      logic [c_DATA_W-1:0] wdata;
      logic [c_RA_W-1:0]   rd;
      logic [c_CTRL_W-1:0] ctrl;
   } ex_mem_pl_t;

   // Occupancy of the head + skid storage
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_buf
//  Description : Two-entry (head + skid) pipeline buffer with registered
//                in_ready. Head drives the output; skid catches the entry
//                that arrives while the head is stalled. Flush empties both.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   skid_state_t      r_state;
   skid_state_t      w_state_nxt;
   logic             r_in_ready;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_skid;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_load_head_in;
   logic             w_load_head_skid;
   logic             w_load_skid;

   assign out_valid  = (r_state != EMPTY);
   assign out_data   = r_head;
   assign in_ready   = r_in_ready;
   assign w_in_xfer  = in_valid && r_in_ready;
   assign w_out_xfer = out_valid && out_ready;

   // Next occupancy and which register captures what; flush overrides all
   always_comb begin
      w_state_nxt      = r_state;
      w_load_head_in   = 1'b0;
      w_load_head_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         w_state_nxt = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  w_state_nxt    = ONE;
                  w_load_head_in = 1'b1;
               end
            end
            ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  w_load_head_in = 1'b1;
               end else if (w_out_xfer) begin
                  w_state_nxt = EMPTY;
               end else if (w_in_xfer) begin
                  w_state_nxt = TWO;
                  w_load_skid = 1'b1;
               end
            end
            TWO: begin
               if (w_out_xfer) begin
                  w_state_nxt      = ONE;
                  w_load_head_skid = 1'b1;
               end
            end
            default: w_state_nxt = EMPTY;
         endcase
      end
   end

   // State register; in_ready is precomputed so it never depends on out_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != TWO);
      end
   end

   // Payload storage; head keeps its last value when the buffer drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_head_in) begin
            r_head <= in_data;
         end else if (w_load_head_skid) begin
            r_head <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= in_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage
//  Description : EX->MEM pipeline register with valid/ready handshake, flush,
//                bubble insertion on an empty head and a saturating
//                back-pressure cycle counter.
//                Build option EX_MEM_SKID_EN: when defined, a two-entry skid
//                buffer gives a registered in_ready; when undefined, a single
//                head register with combinational in_ready is used.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage
   import pipe_pkg::*;
#(
   parameter int                PC_W     = c_PC_W,
   parameter int                DATA_W   = c_DATA_W,
   parameter int                RA_W     = c_RA_W,
   parameter int                CTRL_W   = c_CTRL_W,
   parameter logic [CTRL_W-1:0] CTRL_RST = c_CTRL_RST,
   parameter int                CNT_W    = c_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [RA_W-1:0]   in_rd,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_wdata,
   output logic [RA_W-1:0]   out_rd,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              clr_cnt
);

   localparam int c_PL_W = PC_W + 2 * DATA_W + RA_W + CTRL_W;

   logic [c_PL_W-1:0] w_in_pl;
   logic [c_PL_W-1:0] w_head_pl;
   logic              w_head_valid;
   logic [CTRL_W-1:0] w_head_ctrl;
   logic [CNT_W-1:0]  r_stall_cnt;

   assign w_in_pl = {in_pc, in_alu, in_wdata, in_rd, in_ctrl};

`ifdef EX_MEM_SKID_EN
   pipe_skid_buf #(
      .WIDTH (c_PL_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (w_in_pl),
      .out_valid (w_head_valid),
      .out_ready (out_ready),
      .out_data  (w_head_pl)
   );
`else
   logic              r_valid;
   logic [c_PL_W-1:0] r_head;

   // Single slot: can take a new entry when empty or when the head leaves now
   assign in_ready     = !r_valid || out_ready;
   assign w_head_valid = r_valid;
   assign w_head_pl    = r_head;

   // Head register; flush drops both the held entry and the incoming one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_head  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         r_valid <= 1'b1;
         r_head  <= w_in_pl;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end
`endif

   assign {out_pc, out_alu, out_wdata, out_rd, w_head_ctrl} = w_head_pl;
   assign out_valid = w_head_valid;
   // Empty head presents a bubble so MEM never writes or reads on stale data
   assign out_ctrl  = w_head_valid ? w_head_ctrl : CTRL_RST;
   assign stall_cnt = r_stall_cnt;

   // Saturating count of cycles where MEM holds off a valid entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (clr_cnt) begin
         r_stall_cnt <= '0;
      end else if (w_head_valid && !out_ready && !flush &&
                   (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX→MEM pipeline stage register with valid/ready handshake, flush, bubble insertion and a saturating back-pressure counter. It sits between the ALU/branch unit and the data-memory/SRAM interface. It carries PC, ALU result, store data, destination register and a packed control vector. Stalls propagate without dropping or duplicating an instruction. An optional skid buffer keeps `in_ready` registered while sustaining one transfer per cycle.

## Interface
- `PC_W`, 16: PC width
- `DATA_W`, 32: ALU result / store data width
- `RA_W`, 5: register-file address width
- `CTRL_W`, 8: packed control vector width (RegWrite, MemRead_n, MemtoReg, branch, zero, …)
- `CTRL_RST`, 8'h02: control value for reset and bubbles (MemRead_n=1, all others 0)
- `CNT_W`, 16: stall counter width
- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: EX result valid
- `in_ready` out 1: stage can accept
- `in_pc` in PC_W; `in_alu` in DATA_W; `in_wdata` in DATA_W; `in_rd` in RA_W; `in_ctrl` in CTRL_W
- `flush` in 1: kill all held entries and the current input
- `out_valid` out 1: MEM-side entry valid
- `out_ready` in 1: MEM stage accepts
- `out_pc`, `out_alu`, `out_wdata`, `out_rd`, `out_ctrl` out: head-entry payload
- `stall_cnt` out CNT_W: cycles with `out_valid && !out_ready`, saturating
- `clr_cnt` in 1: synchronous clear of `stall_cnt`

## Operation
- Transfer in: `in_valid && in_ready` at the rising edge. Transfer out: `out_valid && out_ready` at the rising edge.
- Head register drives the outputs. When the head is empty, `out_ctrl` = CTRL_RST and the other payload holds its last value. This is a bubble: no RegWrite, no memory read.
- With skid (see Configuration), storage is head + skid. States are EMPTY, ONE and TWO:
  - EMPTY →ONE on transfer in.
  - ONE: stays in ONE on in+out together (head replaced). Goes to EMPTY on out only. Goes to TWO on in without out (new entry lands in skid).
  - TWO: goes to ONE on out (skid moves to head). `in_ready`=0, so no input is taken.
- `in_ready` = (state != TWO), driven from a register.
- Without skid, storage is head only. `in_ready` = !out_valid || out_ready, combinational from `out_ready`.
- `flush` has priority over all other events. On the next edge, every entry becomes invalid and the state goes to EMPTY. The same-cycle input is dropped even if `in_valid && in_ready`. The head output is not counted as transferred.
- `stall_cnt` increments each cycle with `out_valid && !out_ready && !flush`. It saturates at 2^CNT_W−1. `clr_cnt` has priority over increment.
- Ordering is strict FIFO. No payload field is modified.

## Timing
- Reset (async assert, sync deassert by the integrator) sets:
  - `out_valid`=0, `in_ready`=1
  - `out_pc`/`out_alu`/`out_wdata`/`out_rd`=0, `out_ctrl`=CTRL_RST
  - `stall_cnt`=0, state EMPTY
- Latency is 1 cycle. Input accepted at edge N appears at the outputs after edge N when the stage was empty.
- Throughput is 1 per cycle in both modes with `out_ready` held high.
- Skid mode: `in_ready` falls 1 cycle after the skid fills. No combinational path from `out_ready` to `in_ready`.
- Reset during a stall discards all entries. No partial state survives.

## Configuration
- `EX_MEM_SKID_EN`:
  - Defined: two-entry skid storage, registered `in_ready`, FSM as above.
  - Undefined: single head register, combinational `in_ready`, no skid flops.
- Port list is identical in both builds.

## Structure
- Package `pipe_pkg` holds:
  - the typedef struct `ex_mem_pl_t` {pc, alu, wdata, rd, ctrl}
  - the state enum {EMPTY, ONE, TWO}
  - default width constants and the CTRL bit-index constants
- Sub-module `pipe_skid_buf`: the two-entry storage and FSM, generic over payload width. It is instantiated only under `EX_MEM_SKID_EN`. The top level owns the bubble mux and `stall_cnt`.

## Test plan
- Reset mid-stream with rst_n=0 asynchronously while in state TWO → out_valid=0, out_ctrl=8'h02, in_ready=1, stall_cnt=0 before the next edge.
- Stream of in_alu=1..8 with out_ready=1 → out_alu=1..8 one cycle later, one per cycle, no gaps.
- Back-pressure: send 3 entries (0xA, 0xB, 0xC) with out_ready=0 in skid mode → 0xA at head, 0xB held, in_ready=0, 0xC held off. After out_ready=1, the outputs are 0xA then 0xB, and 0xC is then accepted.
- Flush in state TWO with a simultaneous in_valid → next cycle out_valid=0, out_ctrl=CTRL_RST, nothing emerges later.
- Stall counter with CNT_W=4 and out_valid held with out_ready=0 for 20 cycles → stall_cnt=15. Then clr_cnt → 0.
- Non-skid build with out_ready toggling 1/0 → in_ready tracks out_ready in the same cycle while full, no loss, no duplicate.
